// File: rtl/mor1kx_ram_pkg.sv
// Shared definitions for the multiport RAM: byte lane width, lane count,
// clear-sequencer state encoding and the per-byte even-parity function.
package mor1kx_ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int lanes(input int data_width);
        return data_width / BYTE_W;
    endfunction

    // Stored bit that makes the total number of ones in byte+bit even.
    function automatic logic even_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mor1kx_ram_rdport.sv
// One registered read port: latched array word, per-byte bypass flags,
// captured write data and the output byte mux. Optional parity error
// output under MOR1KX_RAM_PARITY_EN.
module mor1kx_ram_rdport
    import mor1kx_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter bit BYP_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          re_i,
    input  logic [ADDR_WIDTH-1:0]         raddr_i,
    input  logic [ADDR_WIDTH-1:0]         waddr_i,
    input  logic [DATA_WIDTH/BYTE_W-1:0]  we_i,
    input  logic [DATA_WIDTH-1:0]         din_i,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
`ifdef MOR1KX_RAM_PARITY_EN
    input  logic [DATA_WIDTH/BYTE_W-1:0]  mem_rpar_i,
    output logic                          perr_o,
`endif
    output logic [DATA_WIDTH-1:0]         dout_o
);

    localparam int NB = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [NB-1:0]         byp_q, byp_d;
    logic                  addr_hit;

    assign addr_hit = (raddr_i == waddr_i);

`ifdef MOR1KX_RAM_PARITY_EN
    logic          perr_q, perr_d;
    logic [NB-1:0] par_fail;

    // Per-byte parity check of the word coming out of the array.
    always_comb begin
        par_fail = '0;
        for (int b = 0; b < NB; b++) begin
            par_fail[b] = even_par(mem_rdata_i[b*BYTE_W +: BYTE_W]) ^ mem_rpar_i[b];
        end
    end
`endif

    // Next-state: only a granted read refreshes the port, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        din_d   = din_q;
        byp_d   = byp_q;
`ifdef MOR1KX_RAM_PARITY_EN
        perr_d  = perr_q;
`endif
        if (re_i) begin
            rdata_d = mem_rdata_i;
            din_d   = din_i;
            byp_d   = (BYP_EN && addr_hit) ? we_i : '0;
`ifdef MOR1KX_RAM_PARITY_EN
            // Forwarded bytes come from din, so their array parity is irrelevant.
            perr_d  = |(par_fail & ~byp_d);
`endif
        end
    end

    // Port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            din_q   <= '0;
            byp_q   <= '0;
`ifdef MOR1KX_RAM_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            rdata_q <= rdata_d;
            din_q   <= din_d;
            byp_q   <= byp_d;
`ifdef MOR1KX_RAM_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Output mux: forwarded bytes take the captured write data.
    always_comb begin
        dout_o = rdata_q;
        for (int b = 0; b < NB; b++) begin
            if (byp_q[b]) begin
                dout_o[b*BYTE_W +: BYTE_W] = din_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef MOR1KX_RAM_PARITY_EN
    assign perr_o = perr_q;
`endif

endmodule

// File: rtl/mor1kx_multiport_ram_sclk.sv
// Single-clock RAM, one byte-enabled write port, NUM_RD_PORTS read ports.
// After reset a clear sequencer writes INIT_VALUE to every entry; all
// accesses are ignored while busy. Define MOR1KX_RAM_PARITY_EN for
// per-byte parity storage and the perr output.
module mor1kx_multiport_ram_sclk
    import mor1kx_ram_pkg::*;
#(
    parameter int                  ADDR_WIDTH    = 5,
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  NUM_RD_PORTS  = 2,
    parameter string               ENABLE_BYPASS = "TRUE",
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              waddr,
    input  logic [DATA_WIDTH/8-1:0]            we,
    input  logic [DATA_WIDTH-1:0]              din,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] raddr,
    input  logic [NUM_RD_PORTS-1:0]            re,
`ifdef MOR1KX_RAM_PARITY_EN
    output logic [NUM_RD_PORTS-1:0]            perr,
`endif
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] dout,
    output logic                               busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NB     = lanes(DATA_WIDTH);
    localparam bit BYP_EN = (ENABLE_BYPASS == "TRUE");

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    logic [NB-1:0]           wr_be;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NB-1:0]           ext_we;
    logic [NUM_RD_PORTS-1:0] rd_en;

    assign busy   = (state_q == CLEAR);
    assign ext_we = busy ? '0 : we;
    assign rd_en  = busy ? '0 : re;

    // Clear sequencer next state: walk every address once, then go idle.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = READY;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end

    // Clear sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Write port select: sequencer owns the array while clearing.
    always_comb begin
        wr_be   = '0;
        wr_addr = waddr;
        wr_data = din;
        if (!rst) begin
            if (busy) begin
                wr_be   = '1;
                wr_addr = clr_addr_q;
                wr_data = INIT_VALUE;
            end else begin
                wr_be   = we;
            end
        end
    end

    // Byte-enabled array write.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                mem_q[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef MOR1KX_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];

    // Parity array written alongside each byte.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                par_q[wr_addr][b] <= even_par(wr_data[b*BYTE_W +: BYTE_W]);
            end
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];

        mor1kx_ram_rdport #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BYP_EN     (BYP_EN)
        ) u_rdport (
            .clk         (clk),
            .rst         (rst),
            .re_i        (rd_en[p]),
            .raddr_i     (ra),
            .waddr_i     (waddr),
            .we_i        (ext_we),
            .din_i       (din),
            .mem_rdata_i (mem_q[ra]),
`ifdef MOR1KX_RAM_PARITY_EN
            .mem_rpar_i  (par_q[ra]),
            .perr_o      (perr[p]),
`endif
            .dout_o      (dout[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_mor1kx_multiport_ram_sclk.sv
// Bench for mor1kx_multiport_ram_sclk: one instance with bypass, one
// without, driven by the same directed vectors and compared every cycle
// against a word-level memory model, plus literal spot checks.
module tb_mor1kx_multiport_ram_sclk;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NP    = 2;
    localparam int DEPTH = 32;
    localparam logic [31:0] INIT = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  waddr;
    logic [3:0]     we;
    logic [DW-1:0]  din;
    logic [NP*AW-1:0] raddr;
    logic [NP-1:0]  re;
    logic [NP*DW-1:0] dout_b, dout_n;
    logic           busy_b, busy_n;
`ifdef MOR1KX_RAM_PARITY_EN
    logic [NP-1:0]  perr_b, perr_n;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mor1kx_multiport_ram_sclk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
        .ENABLE_BYPASS("TRUE"), .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .rst(rst), .waddr(waddr), .we(we), .din(din),
        .raddr(raddr), .re(re),
`ifdef MOR1KX_RAM_PARITY_EN
        .perr(perr_b),
`endif
        .dout(dout_b), .busy(busy_b)
    );

    mor1kx_multiport_ram_sclk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD_PORTS(NP),
        .ENABLE_BYPASS("FALSE"), .INIT_VALUE(INIT)
    ) dut_nb (
        .clk(clk), .rst(rst), .waddr(waddr), .we(we), .din(din),
        .raddr(raddr), .re(re),
`ifdef MOR1KX_RAM_PARITY_EN
        .perr(perr_n),
`endif
        .dout(dout_n), .busy(busy_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m [DEPTH];
    logic [31:0] e_dout [2][NP];
    logic        e_busy;
    int          clr_left;
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) begin
            clr_left = DEPTH;
            e_busy   = 1'b1;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < NP; p++) e_dout[d][p] = '0;
            started  = 1;
        end else if (started && clr_left > 0) begin
            m[DEPTH - clr_left] = INIT;
            clr_left--;
            e_busy = (clr_left > 0);
        end else if (started) begin
            for (int p = 0; p < NP; p++) begin
                if (re[p]) begin
                    int a;
                    a = int'(raddr[p*AW +: AW]);
                    for (int d = 0; d < 2; d++) begin
                        for (int b = 0; b < 4; b++) begin
                            if (d == 0 && we[b] && a == int'(waddr))
                                e_dout[d][p][b*8 +: 8] = din[b*8 +: 8];
                            else
                                e_dout[d][p][b*8 +: 8] = m[a][b*8 +: 8];
                        end
                    end
                end
            end
            for (int b = 0; b < 4; b++)
                if (we[b]) m[waddr][b*8 +: 8] = din[b*8 +: 8];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("busy_byp", {31'd0, busy_b}, {31'd0, e_busy});
            chk("busy_nobyp", {31'd0, busy_n}, {31'd0, e_busy});
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("dout_byp_p%0d", p), dout_b[p*DW +: DW], e_dout[0][p]);
                chk($sformatf("dout_nobyp_p%0d", p), dout_n[p*DW +: DW], e_dout[1][p]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy_b && n < 100) begin
            n++;
            step();
        end
        chk(name, n, 32);
    endtask

    initial begin
        rst = 1'b1; waddr = '0; we = '0; din = '0; raddr = '0; re = '0;
        repeat (3) step();
        chk("reset_busy", {31'd0, busy_b}, 32'd1);
        chk("reset_dout_p0", dout_b[31:0], 32'd0);
        chk("reset_dout_p1", dout_b[63:32], 32'd0);
`ifdef MOR1KX_RAM_PARITY_EN
        chk("reset_perr", {30'd0, perr_b}, 32'd0);
`endif

        // clear after reset, then read everything back
        rst = 1'b0;
        count_busy("busy_len_initial");
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {AW'(a), AW'(a)}; re = 2'b11;
            step();
            chk("init_p0", dout_b[31:0], INIT);
            chk("init_p1", dout_b[63:32], INIT);
        end

        // byte-enable merge on addr 3
        re = 2'b00; waddr = 5'd3; we = 4'hF; din = 32'h11223344;
        step();
        we = 4'b0101; din = 32'hAABBCCDD;
        step();
        we = 4'h0; raddr = {5'd3, 5'd3}; re = 2'b11;
        step();
        chk("merge_p0", dout_b[31:0], 32'h11BB33DD);
        chk("merge_p1", dout_b[63:32], 32'h11BB33DD);
        chk("merge_nobyp", dout_n[31:0], 32'h11BB33DD);

        // read-during-write on addr 7 (old contents zero)
        re = 2'b00; waddr = 5'd7; we = 4'hF; din = 32'h0;
        step();
        we = 4'b1100; din = 32'hCAFEF00D; raddr = {5'd7, 5'd7}; re = 2'b11;
        step();
        we = 4'h0;
        chk("rdw_byp_p0", dout_b[31:0], 32'hCAFE0000);
        chk("rdw_byp_p1", dout_b[63:32], 32'hCAFE0000);
        chk("rdw_nobyp_p0", dout_n[31:0], 32'h0);
        chk("rdw_nobyp_p1", dout_n[63:32], 32'h0);
        step();
        chk("rdw_after_nobyp", dout_n[31:0], 32'hCAFE0000);

        // read-enable hold on port 0
        re = 2'b00; waddr = 5'd2; we = 4'hF; din = 32'd5;
        step();
        we = 4'h0; raddr = {5'd9, 5'd2}; re = 2'b11;
        step();
        chk("hold_first_p0", dout_b[31:0], 32'd5);
        chk("hold_first_p1", dout_b[63:32], INIT);
        re = 2'b10; we = 4'hF; din = 32'd9;
        step();
        we = 4'h0;
        chk("hold_after_wr_p0", dout_b[31:0], 32'd5);
        step();
        chk("hold_still_p0", dout_b[31:0], 32'd5);
        chk("hold_p1", dout_b[63:32], INIT);
        re = 2'b11;
        step();
        chk("hold_refresh_p0", dout_b[31:0], 32'd9);
        chk("hold_refresh_p1", dout_b[63:32], INIT);

        // reset mid-clear, with writes and reads attempted while busy
        re = 2'b00; rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (17) step();
        chk("midclear_busy", {31'd0, busy_b}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; waddr = 5'd0; we = 4'hF; din = 32'h12345678;
        raddr = {5'd0, 5'd0}; re = 2'b11;
        count_busy("busy_len_restart");
        we = 4'h0;
        chk("busy_dout_zero", dout_b[31:0], 32'd0);
        raddr = {5'd3, 5'd0}; re = 2'b11;
        step();
        chk("restart_addr0", dout_b[31:0], INIT);
        chk("restart_addr3", dout_b[63:32], INIT);

`ifdef MOR1KX_RAM_PARITY_EN
        // corrupt a stored parity bit of addr 4, read it on port 1
        re = 2'b00;
        dut.par_q[4] = dut.par_q[4] ^ 4'b0001;
        raddr = {5'd4, 5'd4}; re = 2'b10;
        step();
        chk("perr", {30'd0, perr_b}, 32'd2);
`endif

        re = 2'b00;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
